// File: rtl/clk_div_monitor.sv
// Divided-clock receive checker: measures high/low/period, lock and stall.
// Optional duty check enabled by defining CLK_DIV_MONITOR_DUTY_CHECK_EN.
module clk_div_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_DIV    = 5,
  parameter int LOCK_CNT   = 4,
  parameter int MAX_PERIOD = 1023
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             locked,
  output logic             timeout,
  output logic             duty_err
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] MAXP  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] EXP   = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [3:0]       LOCKN = 4'(LOCK_CNT);

  logic             sync1_q, sync2_q, dly_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] hlat_q, hlat_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [3:0]       match_q, match_d;
  logic             mv_q, mv_d;
  logic             lock_q, lock_d;
  logic             to_q, to_d;

  logic             rise, fall;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] psat;
  logic [3:0]       match_inc;

  always_comb begin
    rise      = sync2_q & ~dly_q;
    fall      = ~sync2_q & dly_q;
    sum       = {1'b0, hlat_q} + {1'b0, phase_q};
    psat      = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    match_inc = (match_q < LOCKN) ? match_q + 4'd1 : match_q;

    state_d = state_q;
    phase_d = phase_q;
    hlat_d  = hlat_q;
    high_d  = high_q;
    low_d   = low_q;
    per_d   = per_q;
    match_d = match_q;
    mv_d    = 1'b0;
    lock_d  = lock_q;
    to_d    = to_q;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          phase_d = ONE;
        end
      end
      HIGH, LOW: begin
        // A stalled phase wins over any edge arriving on the same cycle
        if (phase_q == MAXP) begin
          to_d    = 1'b1;
          lock_d  = 1'b0;
          match_d = 4'd0;
          state_d = IDLE;
          phase_d = '0;
        end else if (state_q == HIGH && fall) begin
          hlat_d  = phase_q;
          state_d = LOW;
          phase_d = ONE;
        end else if (state_q == LOW && rise) begin
          high_d  = hlat_q;
          low_d   = phase_q;
          per_d   = psat;
          mv_d    = 1'b1;
          state_d = HIGH;
          phase_d = ONE;
          if (psat == EXP) begin
            match_d = match_inc;
            lock_d  = (match_inc >= LOCKN);
          end else begin
            match_d = 4'd0;
            lock_d  = 1'b0;
          end
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      state_q <= IDLE;
      phase_q <= '0;
      hlat_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      per_q   <= '0;
      match_q <= 4'd0;
      mv_q    <= 1'b0;
      lock_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      state_q <= state_d;
      phase_q <= phase_d;
      hlat_q  <= hlat_d;
      high_q  <= high_d;
      low_q   <= low_d;
      per_q   <= per_d;
      match_q <= match_d;
      mv_q    <= mv_d;
      lock_q  <= lock_d;
      to_q    <= to_d;
    end
  end

`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
  logic             duty_q, duty_d;
  logic [CNT_W-1:0] diff;

  always_comb begin
    diff   = (hlat_q > phase_q) ? hlat_q - phase_q : phase_q - hlat_q;
    duty_d = duty_q;
    if (mv_d) duty_d = (diff > ONE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) duty_q <= 1'b0;
    else     duty_q <= duty_d;
  end

  assign duty_err = duty_q;
`else
  assign duty_err = 1'b0;
`endif

  assign meas_valid = mv_q;
  assign high_cnt   = high_q;
  assign low_cnt    = low_q;
  assign period_cnt = per_q;
  assign locked     = lock_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor with a run-length reference model.
// Expects duty checking only when CLK_DIV_MONITOR_DUTY_CHECK_EN is defined.
module tb_clk_div_monitor;

  localparam int CNT_W = 16;
  localparam int EXPD  = 5;
  localparam int LOCKN = 4;
  localparam int MAXP  = 1023;

  logic             clk_in = 0;
  logic             rst = 1;
  logic             sig_in = 0;
  logic             meas_valid;
  logic [CNT_W-1:0] high_cnt, low_cnt, period_cnt;
  logic             locked, timeout, duty_err;

  clk_div_monitor #(
    .CNT_W(CNT_W), .EXP_DIV(EXPD), .LOCK_CNT(LOCKN), .MAX_PERIOD(MAXP)
  ) dut (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
    .meas_valid(meas_valid), .high_cnt(high_cnt), .low_cnt(low_cnt),
    .period_cnt(period_cnt), .locked(locked), .timeout(timeout),
    .duty_err(duty_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int h; int l; int p; bit lk; bit du;
  } meas_t;

  meas_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: operates on run lengths of the sampled level
  int m_state = 0;
  int m_lvl   = 0;
  int m_run   = 0;
  int m_h     = 0;
  int m_match = 0;
  bit m_lock  = 0;
  bit m_to    = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_meas(int h, int l);
    meas_t m;
    int d;
    m.h = h; m.l = l; m.p = h + l;
    if (m.p == EXPD) begin
      if (m_match < LOCKN) m_match++;
      m_lock = (m_match >= LOCKN);
    end else begin
      m_match = 0;
      m_lock  = 0;
    end
    m.lk = m_lock;
    d = (h > l) ? h - l : l - h;
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    m.du = (d > 1);
`else
    m.du = 0;
`endif
    q.push_back(m);
  endtask

  task automatic model_change(int nl);
    if (m_state != 0 && m_run >= MAXP) begin
      m_to = 1; m_match = 0; m_lock = 0; m_state = 0;
      if (m_run == MAXP) begin
        m_lvl = nl; m_run = 0;
        return;
      end
    end
    if (m_state == 0) begin
      if (nl == 1) m_state = 1;
    end else if (m_state == 1) begin
      m_h = m_run; m_state = 2;
    end else begin
      push_meas(m_h, m_run);
      m_state = 1;
    end
    m_lvl = nl;
    m_run = 0;
  endtask

  task automatic drive(int lvl, int n);
    sig_in = lvl[0];
    if (lvl != m_lvl) model_change(lvl);
    repeat (n) begin
      @(negedge clk_in);
      m_run++;
    end
  endtask

  task automatic pat(int h, int l, int reps);
    for (int i = 0; i < reps; i++) begin
      drive(1, h);
      drive(0, l);
    end
  endtask

  task automatic do_reset(string nm);
    #2 rst = 1;
    #1 chk({nm, "_outs"},
           {meas_valid, locked, timeout, duty_err, 28'd0} |
           32'(high_cnt | low_cnt | period_cnt), 32'd0);
    m_state = 0; m_lvl = 0; m_run = 0;
    m_match = 0; m_lock = 0; m_to = 0;
    repeat (2) @(negedge clk_in);
    rst = 0;
  endtask

  always @(negedge clk_in) begin
    if (!rst && meas_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_meas", 32'(period_cnt), 32'hffffffff);
      end else begin
        meas_t e;
        e = q.pop_front();
        n_tests++;
        if (high_cnt !== CNT_W'(e.h) || low_cnt !== CNT_W'(e.l) ||
            period_cnt !== CNT_W'(e.p) || locked !== e.lk ||
            duty_err !== e.du) begin
          n_fail++;
          $display("FAIL meas: got h=%0d l=%0d p=%0d lk=%0b du=%0b want h=%0d l=%0d p=%0d lk=%0b du=%0b",
                   high_cnt, low_cnt, period_cnt, locked, duty_err,
                   e.h, e.l, e.p, e.lk, e.du);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 chk("reset_outs",
           {meas_valid, locked, timeout, duty_err, 28'd0} |
           32'(high_cnt | low_cnt | period_cnt), 32'd0);
    repeat (3) @(negedge clk_in);
    rst = 0;
    repeat (3) @(negedge clk_in);

    pat(3, 2, 6);
    chk("lock_p5", 32'(locked), 32'(m_lock));
    chk("lock_p5_one", 32'(m_lock), 32'd1);
    pat(3, 3, 3);
    drive(1, 3);
    drive(0, 6);
    chk("unlock_p6", 32'(locked), 32'd0);

    pat(3, 2, 6);
    drive(1, 1);
    sig_in = 1;
    repeat (1024) begin
      @(negedge clk_in);
      m_run++;
    end
    chk("stall_early", 32'(timeout), 32'd0);
    @(negedge clk_in);
    m_run++;
    chk("stall_to", 32'(timeout), 32'd1);
    chk("stall_lock", 32'(locked), 32'd0);
    drive(1, 20);
    drive(0, 5);
    pat(3, 2, 2);
    drive(1, 3);
    drive(0, 6);
    chk("to_sticky", 32'(timeout), 32'd1);

    drive(1, 3);
    drive(0, 6);
    do_reset("rst_low");
    repeat (3) @(negedge clk_in);
    pat(3, 2, 2);
    drive(1, 3);
    drive(0, 6);
    chk("rst_to_clr", 32'(timeout), 32'd0);

    pat(4, 1, 3);
    pat(3, 2, 3);
    pat(1, 4, 2);
    pat(2, 2, 2);

    sig_in = 1;
    do_reset("rst_high");
    drive(1, 4);
    pat(0 + 0, 0, 0);
    drive(0, 2);
    pat(3, 2, 3);

    for (int b = 0; b < 30; b++) begin
      if ($urandom_range(0, 1) == 0) begin
        pat(3, 2, int'($urandom_range(2, 6)));
      end else begin
        int h, l;
        h = int'($urandom_range(1, 9));
        l = int'($urandom_range(1, 9));
        pat(h, l, int'($urandom_range(1, 4)));
      end
    end
    drive(1, 3);
    drive(0, 8);
    chk("final_lock", 32'(locked), 32'(m_lock));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
